mem_arbiter: RTL

//  Shares the single-port RAM between instruction fetch (I) and data memory (D) requesters.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/arb_starve_ctr.sv | 38 +++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data RAM arbiter.
// Fair arbitration is enabled with MEM_ARB_FAIR_EN.
package mem_arbiter_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_D = 2'd1,
      GNT_I = 2'd2
   } arb_state_t;

   localparam int unsigned STREAK_W = 3;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive D grants taken while I waits.
// Only present when MEM_ARB_FAIR_EN is defined.
`ifdef MEM_ARB_FAIR_EN
module arb_starve_ctr
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned MAX = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic inc_i,
   input  logic clr_i,
   output logic sat_o
);

   localparam logic [STREAK_W-1:0] MAX_C = STREAK_W'(MAX);

   logic [STREAK_W-1:0] cnt_q, cnt_d;

   assign sat_o = (cnt_q == MAX_C);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && !sat_o)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between fetch (I) and data (D), D first.
// MEM_ARB_FAIR_EN bounds how long I can be starved by D.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned WORD_W      = 32,
   parameter int unsigned MAX_DSTREAK = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [WORD_W-1:0] iaddr,
   output logic              iwait,
   output logic [WORD_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [WORD_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic              dwait,
   output logic [WORD_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  logic [1:0]        ramstate
);

   arb_state_t state_q, state_d;
   ramstate_t  rs;
   logic       dreq;
   logic       force_i;
   logic       take_d;
   logic       take_i;
   logic       in_idle;

   assign rs      = ramstate_t'(ramstate);
   assign dreq    = dREN | dWEN;
   assign in_idle = (state_q == IDLE);
   assign take_d  = dreq & ~force_i;
   assign take_i  = iREN & ~take_d;

`ifdef MEM_ARB_FAIR_EN
   logic sat;

   arb_starve_ctr #(
      .MAX (MAX_DSTREAK)
   ) u_starve_ctr (
      .clk_i (CLK),
      .rst_i (RST),
      .inc_i (in_idle & take_d & iREN),
      .clr_i (in_idle & ~(take_d & iREN)),
      .sat_o (sat)
   );

   assign force_i = iREN & sat;
`else
   logic unused_cfg;

   assign unused_cfg = ^MAX_DSTREAK;
   assign force_i    = 1'b0;
`endif

   assign iload = ramload;
   assign dload = ramload;

   // Outputs are gated by RST so a transfer dies in the reset cycle.
   always_comb begin
      state_d  = state_q;
      iwait    = 1'b1;
      dwait    = 1'b1;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      if (!RST) begin
         unique case (state_q)
            IDLE: begin
               if (take_d)
                  state_d = GNT_D;
               else if (take_i)
                  state_d = GNT_I;
            end
            GNT_D: begin
               if (!dreq) begin
                  state_d = IDLE;
               end else begin
                  ramWEN   = dWEN;
                  ramREN   = dREN & ~dWEN;
                  ramaddr  = daddr;
                  ramstore = dstore;
                  if (rs == ACCESS) begin
                     dwait   = 1'b0;
                     state_d = IDLE;
                  end
               end
            end
            GNT_I: begin
               if (!iREN) begin
                  state_d = IDLE;
               end else begin
                  ramREN  = 1'b1;
                  ramaddr = iaddr;
                  if (rs == ACCESS) begin
                     iwait   = 1'b0;
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

endmodule
